// File: rtl/plot_pkg.sv
// Shared types and helpers for the VGA plot sequencer.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package plot_pkg;

    // Width of a pixel column on the 640x480 trace display
    localparam int X_W   = 9;
    // Width of the FIFO occupancy bus (covers 0..64)
    localparam int LVL_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2
    } state_e;

    // Saturate a sample to the largest plottable column
    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v,
                                              input logic [X_W-1:0] x_max);
        return (v > x_max) ? x_max : v;
    endfunction

endpackage

// File: rtl/plot_sample_fifo.sv
// Synchronous DEPTH x W sample FIFO with occupancy count; head is visible on rdata.
// Latency: a pushed word is poppable the cycle after the push; level updates on the clock edge.
// Backpressure: pushes while full and pops while empty are dropped internally.
module plot_sample_fifo
    import plot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = X_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Storage array: data is only ever read after being written, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/vga_plot_sequencer.sv
// Paces NIOS II ODE samples onto the VGA x_shift, one per FRAMES_PER_SAMPLE frames, only at vsync.
// Latency: x_shift moves 5 clk after the vsync pin edge that makes an update due (sync 2 + edge 1 + ARMED 1 + LOAD 1).
// Backpressure: s_ready low while FIFO full; optional PLOT_UNDERFLOW_CNT_EN adds saturating underflow_cnt.
module vga_plot_sequencer
    import plot_pkg::*;
#(
    parameter int DEPTH             = 8,
    parameter int FRAMES_PER_SAMPLE = 1,
    parameter int X_MAX             = 479,
    parameter int VSYNC_ACTIVE      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [X_W-1:0]   s_data,
    input  logic             vsync_in,
    output logic [X_W-1:0]   x_shift,
    output logic [LVL_W-1:0] level,
    output logic             underflow
`ifdef PLOT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]      underflow_cnt
`endif
);

    localparam logic [X_W-1:0] XMAX_C   = X_W'(X_MAX);
    localparam logic [7:0]     FPS_LAST = 8'(FRAMES_PER_SAMPLE - 1);
    localparam logic           V_ACT    = (VSYNC_ACTIVE != 0);

    // Synchroniser, edge detector and frame tick
    logic sync1_q, sync2_q, sync3_q;
    logic tick_q;

    // FSM and datapath state
    state_e         state_q, state_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [X_W-1:0] x_shift_q;
    logic           underflow_q, underflow_d;
    logic           due;
    logic           pop;

    // FIFO interface
    logic             push_acc;
    logic [X_W-1:0]   fifo_rdata;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    assign s_ready  = !fifo_full;
    assign push_acc = s_valid && s_ready;
    assign level    = fifo_level;
    assign x_shift  = x_shift_q;
    assign underflow = underflow_q;

    plot_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (X_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc),
        .wdata (clamp_x(s_data, XMAX_C)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bring vsync into the clk domain and register a pulse on entry to the active level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ~V_ACT;
            sync2_q <= ~V_ACT;
            sync3_q <= ~V_ACT;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vsync_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= (sync2_q == V_ACT) && (sync3_q != V_ACT);
        end
    end

    // A frame tick makes an update due when it closes the last frame of the hold period
    assign due = tick_q && (frame_cnt_q == FPS_LAST);

    // Next-state, frame counting, pop request and underflow detection
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;
        underflow_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Frames keep being counted while starved so the cadence stays intact
                if (tick_q) begin
                    frame_cnt_d = due ? 8'd0 : frame_cnt_q + 8'd1;
                    underflow_d = due && (fifo_level == '0);
                end
                if (fifo_level != '0) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (tick_q) begin
                    if (due) begin
                        frame_cnt_d = 8'd0;
                        state_d     = LOAD;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            LOAD: begin
                // Ticks landing here are dropped; occupancy after the pop picks the next state
                pop = !fifo_empty;
                if ((fifo_level > LVL_W'(1)) || push_acc) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, frame counter and underflow pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= 8'd0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // x_shift only moves on the edge that ends LOAD, so the column is stable within a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            x_shift_q <= '0;
        end else if (state_q == LOAD && !fifo_empty) begin
            x_shift_q <= fifo_rdata;
        end
    end

`ifdef PLOT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_q;

    assign underflow_cnt = underflow_cnt_q;

    // Saturating tally of starved updates for software diagnostics
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt_q <= 16'd0;
        end else if (underflow_q && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_plot_sequencer.sv
// Bench for vga_plot_sequencer: directed vector table, corner sequences, randomized model compare.
// Latency: checks exact 5-clk vsync-to-x_shift timing on the FRAMES_PER_SAMPLE=1 instance.
// Backpressure: checks s_ready against a model FIFO occupancy.
module tb_vga_plot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [8:0] s_data = 9'd0;
    logic       vsync = 1'b1;

    logic       rdy1, rdy3, uf1, uf3;
    logic [8:0] x1, x3;
    logic [6:0] lvl1, lvl3;
`ifdef PLOT_UNDERFLOW_CNT_EN
    logic [15:0] ucnt1, ucnt3;
`endif

    int checks = 0;
    int errors = 0;
    int ufc[2] = '{0, 0};

    always #5 clk = ~clk;

    vga_plot_sequencer #(.DEPTH(8), .FRAMES_PER_SAMPLE(1), .X_MAX(479), .VSYNC_ACTIVE(0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
        .vsync_in(vsync), .x_shift(x1), .level(lvl1), .underflow(uf1)
`ifdef PLOT_UNDERFLOW_CNT_EN
        , .underflow_cnt(ucnt1)
`endif
    );

    vga_plot_sequencer #(.DEPTH(8), .FRAMES_PER_SAMPLE(3), .X_MAX(479), .VSYNC_ACTIVE(0)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy3), .s_data(s_data),
        .vsync_in(vsync), .x_shift(x3), .level(lvl3), .underflow(uf3)
`ifdef PLOT_UNDERFLOW_CNT_EN
        , .underflow_cnt(ucnt3)
`endif
    );

    // Count cycles in which each underflow output is high
    always @(negedge clk) begin
        if (uf1) ufc[0] <= ufc[0] + 1;
        if (uf3) ufc[1] <= ufc[1] + 1;
    end

    localparam int OP_PUSH = 0;
    localparam int OP_VS   = 1;

    typedef struct {
        int op;
        int data;
        int exp_x;
        int exp_lvl;
        int exp_rdy;
        int exp_uf;
    } vec_t;

    function automatic vec_t mk(input int op, input int d, input int x, input int l, input int r, input int u);
        vec_t v;
        v.op = op; v.data = d; v.exp_x = x; v.exp_lvl = l; v.exp_rdy = r; v.exp_uf = u;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; vsync = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic push1(input int d);
        s_valid = 1'b1; s_data = 9'(d);
        cyc();
        s_valid = 1'b0;
    endtask

    // One vsync pulse on dut1 with exact timing: old x through edge 4, new x after edge 5
    task automatic vs_edge(input string nm, input int old_x, input int exp_x, input int exp_lvl, input int exp_uf);
        vsync = 1'b0;
        repeat (4) cyc();
        chk({nm, " x before edge5"}, 32'(x1), 32'(old_x));
        chk({nm, " underflow"}, 32'(uf1), 32'(exp_uf));
        cyc();
        chk({nm, " x at edge5"}, 32'(x1), 32'(exp_x));
        chk({nm, " level"}, 32'(lvl1), 32'(exp_lvl));
        chk({nm, " underflow 1-cycle"}, 32'(uf1), 32'd0);
        vsync = 1'b1;
        repeat (4) cyc();
    endtask

    // Abstract reference model: per-instance FIFO contents, frame count and last shown column
    int mq[2][8];
    int mhead[2], mcnt[2], mfc[2], mx[2], muf[2], ufbase[2];
    int fps[2] = '{1, 3};

    function automatic int clampm(input int v);
        return (v > 479) ? 479 : v;
    endfunction

    initial begin
        vec_t tbl[16];
        int prev_x;
        int exp3;

        tbl[0]  = mk(OP_PUSH, 100, 0, 1, 1, 0);
        tbl[1]  = mk(OP_PUSH, 200, 0, 2, 1, 0);
        tbl[2]  = mk(OP_PUSH, 300, 0, 3, 1, 0);
        tbl[3]  = mk(OP_VS,   0, 100, 2, 1, 0);
        tbl[4]  = mk(OP_VS,   0, 200, 1, 1, 0);
        tbl[5]  = mk(OP_VS,   0, 300, 0, 1, 0);
        tbl[6]  = mk(OP_VS,   0, 300, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            tbl[7 + i] = mk(OP_PUSH, 11 + i, 300, i + 1, (i < 7) ? 1 : 0, 0);
        end
        tbl[15] = mk(OP_PUSH, 99, 300, 8, 0, 0);

        // Reset state
        do_reset();
        chk("reset level", 32'(lvl1), 32'd0);
        chk("reset x_shift", 32'(x1), 32'd0);
        chk("reset underflow", 32'(uf1), 32'd0);
        chk("reset s_ready", 32'(rdy1), 32'd1);

        // Directed table: fill, drain on vsync, underflow, fill to full
        prev_x = 0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].op == OP_PUSH) begin
                push1(tbl[i].data);
                chk($sformatf("vec%0d level", i), 32'(lvl1), 32'(tbl[i].exp_lvl));
                chk($sformatf("vec%0d s_ready", i), 32'(rdy1), 32'(tbl[i].exp_rdy));
                chk($sformatf("vec%0d x_shift", i), 32'(x1), 32'(tbl[i].exp_x));
            end else begin
                vs_edge($sformatf("vec%0d", i), prev_x, tbl[i].exp_x, tbl[i].exp_lvl, tbl[i].exp_uf);
            end
            prev_x = tbl[i].exp_x;
        end
`ifdef PLOT_UNDERFLOW_CNT_EN
        chk("underflow_cnt after starve", 32'(ucnt1), 32'd1);
`endif

        // Push held across the LOAD edge while full: pop happens, push is refused
        s_valid = 1'b1; s_data = 9'd77; vsync = 1'b0;
        repeat (5) cyc();
        s_valid = 1'b0;
        chk("full push+pop level", 32'(lvl1), 32'd7);
        chk("full push+pop x_shift", 32'(x1), 32'd11);
        chk("full push+pop s_ready", 32'(rdy1), 32'd1);
        vsync = 1'b1;
        repeat (4) cyc();

        // Clamp of an out-of-range sample
        do_reset();
        push1(511);
        vs_edge("clamp", 0, 479, 0, 0);

        // FRAMES_PER_SAMPLE=3: x changes only on the 3rd and 6th frame
        do_reset();
        push1(40);
        push1(50);
        for (int e = 1; e <= 6; e++) begin
            vsync = 1'b0;
            repeat (6) cyc();
            vsync = 1'b1;
            repeat (3) cyc();
            exp3 = (e < 3) ? 0 : ((e < 6) ? 40 : 50);
            chk($sformatf("fps3 edge%0d x_shift", e), 32'(x3), 32'(exp3));
        end

        // Reset landing on the LOAD cycle discards everything
        do_reset();
        for (int i = 0; i < 4; i++) push1(i + 1);
        vsync = 1'b0;
        repeat (4) cyc();
        rst = 1'b1; vsync = 1'b1;
        cyc();
        chk("rst in LOAD level", 32'(lvl1), 32'd0);
        chk("rst in LOAD x_shift", 32'(x1), 32'd0);
        chk("rst in LOAD s_ready", 32'(rdy1), 32'd1);
        rst = 1'b0;
        cyc();
        vsync = 1'b0;
        repeat (6) cyc();
        chk("post-rst vsync x_shift", 32'(x1), 32'd0);
        chk("post-rst vsync level", 32'(lvl1), 32'd0);
        vsync = 1'b1;
        repeat (3) cyc();

        // Randomized traffic against the abstract model, both hold periods
        do_reset();
        cyc();
        for (int d = 0; d < 2; d++) begin
            mhead[d] = 0; mcnt[d] = 0; mfc[d] = 0; mx[d] = 0; muf[d] = 0; ufbase[d] = ufc[d];
        end
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                int v;
                v = $urandom_range(0, 511);
                s_valid = 1'b1; s_data = 9'(v);
                chk($sformatf("rnd%0d s_ready fps1", r), 32'(rdy1), 32'(mcnt[0] < 8));
                chk($sformatf("rnd%0d s_ready fps3", r), 32'(rdy3), 32'(mcnt[1] < 8));
                for (int d = 0; d < 2; d++) begin
                    if (mcnt[d] < 8) begin
                        mq[d][(mhead[d] + mcnt[d]) % 8] = clampm(v);
                        mcnt[d]++;
                    end
                end
                cyc();
                s_valid = 1'b0;
                cyc();
            end
            vsync = 1'b0;
            repeat (8) cyc();
            vsync = 1'b1;
            repeat (3) cyc();
            for (int d = 0; d < 2; d++) begin
                mfc[d]++;
                if (mfc[d] == fps[d]) begin
                    mfc[d] = 0;
                    if (mcnt[d] > 0) begin
                        mx[d] = mq[d][mhead[d]];
                        mhead[d] = (mhead[d] + 1) % 8;
                        mcnt[d]--;
                    end else begin
                        muf[d]++;
                    end
                end
            end
            chk($sformatf("rnd%0d x_shift fps1", r), 32'(x1), 32'(mx[0]));
            chk($sformatf("rnd%0d x_shift fps3", r), 32'(x3), 32'(mx[1]));
            chk($sformatf("rnd%0d level fps1", r), 32'(lvl1), 32'(mcnt[0]));
            chk($sformatf("rnd%0d level fps3", r), 32'(lvl3), 32'(mcnt[1]));
            chk($sformatf("rnd%0d underflow cycles fps1", r), 32'(ufc[0] - ufbase[0]), 32'(muf[0]));
            chk($sformatf("rnd%0d underflow cycles fps3", r), 32'(ufc[1] - ufbase[1]), 32'(muf[1]));
        end
`ifdef PLOT_UNDERFLOW_CNT_EN
        chk("rnd underflow_cnt fps1", 32'(ucnt1), 32'(muf[0]));
        chk("rnd underflow_cnt fps3", 32'(ucnt3), 32'(muf[1]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
